bsg_dff_rr_share: RTL
=====================

Name: bsg_dff_rr_share

Overview:
- Shares a single width_p-bit output register among els_p requesters using round-robin arbitration.
- Each requester presents data with a valid/ready handshake. One winner per cycle is captured into the register and presented downstream with its requester id.
- Sits in front of a shared pipeline register, for example a shared write or response port, where several producers feed one registered consumer.

Parameters:
- width_p, 32, data width per requester and of the shared register.
- els_p, 4, number of requesters; must be >= 1; need not be a power of 2.
- lg_els_lp, `BSG_SAFE_CLOG2(els_p), derived width of the id and the pointer; not overridable.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  els_p  per-requester valid.
- data_i  input  els_p*width_p  requester k's data is in bits [k*width_p +: width_p].
- ready_o  output  els_p  one-hot-or-zero grant; requester k transfers when v_i[k] & ready_o[k].
- v_o  output  1  shared register holds valid data.
- data_o  output  width_p  registered data of the last accepted transfer.
- id_o  output  lg_els_lp  index of the requester that supplied data_o.
- ready_i  input  1  downstream accepts; a transfer out occurs when v_o & ready_i.

Behaviour:
- Reset values: v_o=0, id_o=0, and the round-robin pointer last_r=els_p-1, so requester 0 has highest priority first. data_o is not reset and is don't-care while v_o=0.
- Acceptance condition: accept_en = ~v_o | ready_i. This allows full throughput of one word per cycle when ready_i is held high.
- Grant selection:
  - When accept_en=1, grant the first k with v_i[k]=1, searching upward from (last_r+1) mod els_p with wrap-around.
  - ready_o has exactly that bit set.
  - When accept_en=0 or no v_i is set, ready_o=0.
- Grant is combinational from v_i, v_o, ready_i and last_r. Requesters must not make v_i depend on ready_o. ready_i may depend on v_o.
- On a grant at the clock edge:
  - data_o <= data of the winner, id_o <= winner index, v_o <= 1.
  - last_r <= winner index.
- Latency: a transfer accepted in cycle n appears at v_o/data_o in cycle n+1.
- Drain with no new grant (v_o & ready_i and no v_i): v_o <= 0; data_o, id_o and last_r hold.
- Stall (v_o & ~ready_i): data_o, id_o and v_o hold; ready_o=0; last_r holds.
- Simultaneous drain and grant: the new word replaces the old one in the same edge, with no bubble.
- Pointer wrap: the search order is modulo els_p, including non-power-of-2 els_p. last_r never takes a value >= els_p.
- els_p=1: acts as a plain one-entry register slice. id_o is always 0, and the pointer is constant.
- Reset mid-operation: on the edge where reset_i=1, v_o <= 0 and last_r <= els_p-1 regardless of other inputs. While reset_i=1, ready_o=0.
- Fairness: with all requesters continuously valid and ready_i=1, each requester is granted exactly once in every els_p consecutive grants.

Decomposition:
- No package typedefs are needed. Widths come from the shared `BSG_SAFE_CLOG2 macro.
- Sub-module bsg_dff_rr_share_arb contains the combinational round-robin priority search. It takes v_i, last_r and an enable, and produces a one-hot grant plus an encoded index.
- The top level holds the data, id and valid registers, the pointer register, and the handshake logic.

Test Plan:
- Reset then idle: reset_i=1 for 2 cycles, then v_i=0 -> v_o=0, ready_o=0 throughout. The first grant after reset with v_i=4'b1111 goes to requester 0 (ready_o=4'b0001).
- Full rotation: els_p=4, v_i=4'b1111, ready_i=1, data_i[k]=32'hA0+k. Expected sequence:
  - ready_o cycles 0001, 0010, 0100, 1000, 0001, ...
  - one cycle later, data_o/id_o = A0/0, A1/1, A2/2, A3/3, with v_o continuously 1.
- Backpressure: v_o=1 holding data 32'hDEAD, id 2, with ready_i=0 for 3 cycles and v_i=4'b1111 -> ready_o=0 and data_o, id_o, v_o stable for all 3 cycles. Raising ready_i grants requester 3 in that cycle.
- Sparse skip and wrap: last grant was 1, v_i=4'b0001 -> grant goes to 0 by wrap, with id_o=0 the next cycle. Then v_i=4'b0101 -> grant goes to 2.
- Non-power-of-2: els_p=3, all valid, 7 consecutive grants -> ids 0,1,2,0,1,2,0. id_o never equals 3.
- Mid-stream reset: during a rotation with v_o=1, assert reset_i for 1 cycle -> next cycle v_o=0. The first post-reset grant goes to requester 0 even if the prior grant was 0.

Source files
------------

// File: rtl/bsg_dff_rr_share_pkg.sv
// Shared width macro and index helpers for the round-robin shared register slice.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2((x)))
`endif

package bsg_dff_rr_share_pkg;

    // Adds an offset in [0, n] to a base in [0, n-1] modulo n without a divider.
    function automatic int wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) sum = sum - n;
        return sum;
    endfunction

endpackage

// File: rtl/bsg_dff_rr_share_arb.sv
// Combinational round-robin search: first valid requester above last_i, with wrap-around.
module bsg_dff_rr_share_arb
    import bsg_dff_rr_share_pkg::*;
#(
    parameter int els_p     = 4,
    parameter int lg_els_lp = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic [els_p-1:0]     v_i,
    input  logic [lg_els_lp-1:0] last_i,
    input  logic                 en_i,
    output logic [els_p-1:0]     grant_o,
    output logic [lg_els_lp-1:0] idx_o,
    output logic                 v_o
);

    logic found;

    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int i = 1; i <= els_p; i++) begin
            int k;
            k = wrap_add(int'(last_i), i, els_p);
            if (en_i && !found && v_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = lg_els_lp'(k);
            end
        end
    end

    assign v_o = found;

endmodule

// File: rtl/bsg_dff_rr_share.sv
// One width_p register shared by els_p valid/ready requesters under round-robin arbitration.
module bsg_dff_rr_share
    import bsg_dff_rr_share_pkg::*;
#(
    parameter int width_p   = 32,
    parameter int els_p     = 4,
    localparam int lg_els_lp = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [lg_els_lp-1:0]       id_o,
    input  logic                       ready_i
);

    logic [lg_els_lp-1:0] last_r;
    logic [lg_els_lp-1:0] win_idx;
    logic                 win_v;
    logic                 accept_en;

    // The slot can take a new word when empty or when its current word leaves this cycle.
    assign accept_en = ~v_o | ready_i;

    bsg_dff_rr_share_arb #(
        .els_p     (els_p),
        .lg_els_lp (lg_els_lp)
    ) arb (
        .v_i     (v_i),
        .last_i  (last_r),
        .en_i    (accept_en & ~reset_i),
        .grant_o (ready_o),
        .idx_o   (win_idx),
        .v_o     (win_v)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o    <= 1'b0;
            id_o   <= '0;
            last_r <= lg_els_lp'(els_p - 1);
        end else if (win_v) begin
            v_o    <= 1'b1;
            id_o   <= win_idx;
            last_r <= win_idx;
        end else if (ready_i) begin
            v_o    <= 1'b0;
        end
    end

    // NOTE: the data register is deliberately left out of reset; it is qualified by
    // v_o, so resetting it would only add reset fan-out to a wide datapath.
    always_ff @(posedge clk_i) begin
        if (win_v) begin
            data_o <= data_i[win_idx*width_p +: width_p];
        end
    end

endmodule
